// File: rtl/ccff_chain_loader.sv
// ---------------------------------------------------------------------------------------------
// ccff_chain_loader
//
// Loads a configuration flip-flop chain (e.g. a cby tile) from a valid/ready word stream.
// Words are serialised MSB-first onto ccff_head. Exactly CHAIN_LEN bits are shifted per load.
// chain_clk_en is a registered enable intended to gate prog_clk to the chain, so the chain only
// moves on edges where a valid bit is presented. While loading, the old chain contents leaving
// ccff_tail are folded into a running parity.
//
// Ports
//   prog_clk      in   configuration clock, all state on the rising edge
//   pReset        in   asynchronous active-high reset
//   start         in   single-cycle load request, honoured only when idle
//   s_valid       in   input word valid
//   s_data        in   input word, bit DATA_WIDTH-1 is shifted first
//   s_ready       out  loader accepts s_data this cycle
//   ccff_head     out  serial data to chain head (flop output)
//   chain_clk_en  out  chain captures on the edge ending a cycle where this is 1 (flop output)
//   ccff_tail     in   serial data from chain tail
//   busy          out  load in progress
//   done          out  one-cycle pulse after the last bit has been shifted
//   bit_count     out  bits shifted so far in the current load
//   tail_parity   out  XOR of ccff_tail over every enabled edge of the current load
// ---------------------------------------------------------------------------------------------
module ccff_chain_loader #(
  parameter int unsigned CHAIN_LEN  = 58,
  parameter int unsigned DATA_WIDTH = 8,
  // Derived from CHAIN_LEN; leave at its default.
  parameter int unsigned CNT_W      = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  ccff_head,
  output logic                  chain_clk_en,
  input  logic                  ccff_tail,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      bit_count,
  output logic                  tail_parity
);

  localparam int unsigned WCNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] WORD_BITS = WCNT_W'(DATA_WIDTH);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [WCNT_W-1:0]     r_wcnt;
  logic [CNT_W-1:0]      r_bit_count;
  logic                  r_tail_parity;
  logic                  r_chain_clk_en;

  logic [1:0]            w_state_d;
  logic [DATA_WIDTH-1:0] w_shreg_d;
  logic [WCNT_W-1:0]     w_wcnt_d;
  logic [CNT_W-1:0]      w_bit_count_d;
  logic                  w_tail_parity_d;
  logic                  w_chain_clk_en_d;

  always_comb begin
    w_state_d       = r_state;
    w_shreg_d       = r_shreg;
    w_wcnt_d        = r_wcnt;
    w_bit_count_d   = r_bit_count;
    w_tail_parity_d = r_tail_parity;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_d       = ST_FETCH;
          w_bit_count_d   = '0;
          w_tail_parity_d = 1'b0;
        end
      end

      ST_FETCH: begin
        if (s_valid) begin
          w_shreg_d = s_data;
          w_wcnt_d  = WORD_BITS;
          w_state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // The chain shifts on this same edge, so ccff_tail still shows the old tail bit.
        w_tail_parity_d = r_tail_parity ^ ccff_tail;
        w_shreg_d       = r_shreg << 1;
        w_bit_count_d   = r_bit_count + CNT_ONE;
        w_wcnt_d        = r_wcnt - WCNT_ONE;
        if (r_bit_count == LAST_BIT) begin
          // Chain is full: drop the unused tail of the word so ccff_head returns to 0.
          w_state_d = ST_DONE;
          w_shreg_d = '0;
          w_wcnt_d  = '0;
        end else if (r_wcnt == WCNT_ONE) begin
          w_state_d = ST_FETCH;
        end
      end

      ST_DONE: begin
        w_state_d = ST_IDLE;
      end

      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  // Enable is a dedicated flop so the clock gate sees a glitch-free, full-cycle level.
  always_comb begin
    w_chain_clk_en_d = (w_state_d == ST_SHIFT);
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state        <= ST_IDLE;
      r_shreg        <= '0;
      r_wcnt         <= '0;
      r_bit_count    <= '0;
      r_tail_parity  <= 1'b0;
      r_chain_clk_en <= 1'b0;
    end else begin
      r_state        <= w_state_d;
      r_shreg        <= w_shreg_d;
      r_wcnt         <= w_wcnt_d;
      r_bit_count    <= w_bit_count_d;
      r_tail_parity  <= w_tail_parity_d;
      r_chain_clk_en <= w_chain_clk_en_d;
    end
  end

  assign s_ready      = (r_state == ST_FETCH);
  assign busy         = (r_state == ST_FETCH) || (r_state == ST_SHIFT);
  assign done         = (r_state == ST_DONE);
  assign ccff_head    = r_shreg[DATA_WIDTH-1];
  assign chain_clk_en = r_chain_clk_en;
  assign bit_count    = r_bit_count;
  assign tail_parity  = r_tail_parity;

  // Structural invariants of the loader.
  a_ready_not_shifting : assert property (@(posedge prog_clk) disable iff (pReset)
    !(s_ready && chain_clk_en));
  a_done_not_busy : assert property (@(posedge prog_clk) disable iff (pReset)
    done |-> !busy);
  a_count_in_range : assert property (@(posedge prog_clk) disable iff (pReset)
    32'(bit_count) <= CHAIN_LEN);
  a_done_full_count : assert property (@(posedge prog_clk) disable iff (pReset)
    done |-> (32'(bit_count) == CHAIN_LEN));

endmodule

// File: tb/tb_ccff_chain_loader.sv
// ---------------------------------------------------------------------------------------------
// tb_ccff_chain_loader
//
// Drives ccff_chain_loader with directed word streams into a behavioural CHAIN_LEN-bit chain
// clocked on chain_clk_en. A transaction-level reference model predicts every output each
// cycle; literal expectations (final image, done cycle, parity) pin the model.
// ---------------------------------------------------------------------------------------------
module tb_ccff_chain_loader;

  localparam int unsigned CL = 58;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = $clog2(CL + 1);

  localparam logic [7:0]    WORDS [8] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h5A, 8'hC0};
  localparam logic [63:0]   STREAM    = 64'hA53CFF00817E5AC0;
  // First stream bit ends at the tail (index CL-1): the image is the top 58 stream bits.
  localparam logic [CL-1:0] EXP_IMAGE = CL'(STREAM >> 6);

  logic          prog_clk = 1'b0;
  logic          pReset   = 1'b1;
  logic          start    = 1'b0;
  logic          s_valid  = 1'b0;
  logic [DW-1:0] s_data   = '0;
  logic          s_ready;
  logic          ccff_head;
  logic          chain_clk_en;
  logic          ccff_tail;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_count;
  logic          tail_parity;

  int n_checks = 0;
  int n_errors = 0;
  int en_edges = 0;

  ccff_chain_loader #(
    .CHAIN_LEN  (CL),
    .DATA_WIDTH (DW)
  ) dut (
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_ready      (s_ready),
    .ccff_head    (ccff_head),
    .chain_clk_en (chain_clk_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .bit_count    (bit_count),
    .tail_parity  (tail_parity)
  );

  always #5 prog_clk = ~prog_clk;

  // Downstream configuration chain: index 0 is the head, CL-1 the tail.
  logic [CL-1:0] chain       = '0;
  logic [CL-1:0] preload_val = '0;
  logic          preload_req = 1'b0;

  always @(posedge prog_clk) begin
    if (preload_req)       chain <= preload_val;
    else if (chain_clk_en) chain <= {chain[CL-2:0], ccff_head};
  end
  assign ccff_tail = chain[CL-1];

  initial forever begin
    @(posedge prog_clk);
    if (chain_clk_en === 1'b1) en_edges++;
  end

  // Reference model: a load is active until CL bits have gone out; while active it either
  // waits for a word (no bits held) or emits the held word MSB-first.
  bit            m_active = 1'b0;
  bit            m_done   = 1'b0;
  int            m_wbits  = 0;
  logic [DW-1:0] m_word   = '0;
  int            m_count  = 0;
  bit            m_par    = 1'b0;

  initial forever begin
    @(posedge prog_clk or posedge pReset);
    if (pReset) begin
      m_active = 1'b0; m_done = 1'b0; m_wbits = 0; m_word = '0; m_count = 0; m_par = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1'b1; m_count = 0; m_par = 1'b0; m_wbits = 0;
      end
    end else if (m_wbits == 0) begin
      if (s_valid) begin
        m_word = s_data; m_wbits = int'(DW);
      end
    end else begin
      m_par = m_par ^ ccff_tail;
      m_count++;
      m_wbits--;
      m_word = m_word << 1;
      if (m_count == int'(CL)) begin
        m_active = 1'b0; m_done = 1'b1; m_wbits = 0; m_word = '0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    bit exp_wait;
    bit exp_emit;
    forever begin
      @(negedge prog_clk);
      exp_wait = m_active && (m_wbits == 0);
      exp_emit = m_active && (m_wbits != 0);
      check("cyc_s_ready",      64'(s_ready),      64'(exp_wait));
      check("cyc_chain_clk_en", 64'(chain_clk_en), 64'(exp_emit));
      check("cyc_ccff_head",    64'(ccff_head),    64'(exp_emit ? m_word[DW-1] : 1'b0));
      check("cyc_busy",         64'(busy),         64'(m_active));
      check("cyc_done",         64'(done),         64'(m_done));
      check("cyc_bit_count",    64'(bit_count),    64'(m_count));
      check("cyc_tail_parity",  64'(tail_parity),  64'(m_par));
    end
  end

  task automatic check_reset_outputs();
    check("rst_s_ready",      64'(s_ready),      64'(0));
    check("rst_ccff_head",    64'(ccff_head),    64'(0));
    check("rst_chain_clk_en", 64'(chain_clk_en), 64'(0));
    check("rst_busy",         64'(busy),         64'(0));
    check("rst_done",         64'(done),         64'(0));
    check("rst_bit_count",    64'(bit_count),    64'(0));
    check("rst_tail_parity",  64'(tail_parity),  64'(0));
  endtask

  task automatic preload(input logic [CL-1:0] v);
    preload_val = v;
    preload_req = 1'b1;
    @(posedge prog_clk); #1;
    preload_req = 1'b0;
  endtask

  // Called just after a rising edge. Cycle 1 is the cycle carrying start.
  task automatic run_load(input bit stall, input bit poke, input bit abort,
                          output int done_cyc, output int n_done, output int n_en);
    int widx;
    int cyc;
    int stall_left;
    int base;
    bit pv;
    bit pr;
    widx = 0; cyc = 1; stall_left = 0; base = en_edges;
    done_cyc = 0; n_done = 0; n_en = 0;
    start = 1'b1; s_valid = 1'b1; s_data = WORDS[0];
    pv = 1'b1; pr = s_ready;
    while (cyc < 300) begin
      @(posedge prog_clk); #1;
      cyc++;
      if (pv && pr) begin
        widx++;
        if (stall && (widx == 2 || widx == 6)) stall_left = 5;
      end
      start = poke && (cyc == 25 || cyc == 68);
      if (done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (poke && cyc >= 69) check("busy_after_done", 64'(busy), 64'(0));
      if (abort && (en_edges - base) == 20) begin
        #2;
        pReset = 1'b1;
        #1;
        check_reset_outputs();
        break;
      end
      if (stall_left > 0 && s_ready) begin
        s_valid = 1'b0;
        stall_left--;
        check("stall_clk_en", 64'(chain_clk_en), 64'(0));
      end else begin
        s_valid = (widx < 8);
        s_data  = WORDS[(widx < 8) ? widx : 0];
      end
      pv = s_valid;
      pr = s_ready;
      if (done_cyc != 0 && cyc >= done_cyc + 3) break;
    end
    if (!abort && done_cyc == 0) check("done_timeout", 64'(0), 64'(1));
    start   = 1'b0;
    s_valid = 1'b0;
    n_en    = en_edges - base;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    int nd;
    int ne;

    // Reset release, random traffic, then an asynchronous mid-cycle reset.
    repeat (3) @(posedge prog_clk);
    #3 pReset = 1'b0;
    repeat (30) begin
      @(posedge prog_clk); #1;
      start   = ($urandom_range(0, 7) == 0);
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
    end
    @(posedge prog_clk); #3;
    pReset = 1'b1;
    #1;
    check_reset_outputs();
    repeat (3) begin
      @(posedge prog_clk); #1;
      start = 1'b1; s_valid = 1'b1;
      check("busy_in_reset",    64'(busy),    64'(0));
      check("s_ready_in_reset", 64'(s_ready), 64'(0));
    end
    @(posedge prog_clk); #1;
    start = 1'b0; s_valid = 1'b0;
    #2 pReset = 1'b0;
    @(posedge prog_clk); #1;
    check("busy_after_reset", 64'(busy), 64'(0));

    // Full load, no stalls, empty chain.
    preload('0);
    run_load(1'b0, 1'b0, 1'b0, dc, nd, ne);
    check("a_done_cycle", 64'(dc), 64'(68));
    check("a_done_count", 64'(nd), 64'(1));
    check("a_en_edges",   64'(ne), 64'(58));
    check("a_image",      64'(chain), 64'(EXP_IMAGE));
    check("a_bit_count",  64'(bit_count), 64'(58));
    check("a_parity",     64'(tail_parity), 64'(0));

    // s_valid while idle is neither accepted nor consumed.
    repeat (3) begin
      s_valid = 1'b1; s_data = 8'h12;
      @(posedge prog_clk); #1;
      check("idle_s_ready", 64'(s_ready), 64'(0));
    end
    s_valid = 1'b0;

    // Stalled load, chain holding a single 1.
    preload(CL'(1) << 30);
    run_load(1'b1, 1'b0, 1'b0, dc, nd, ne);
    check("b_done_cycle", 64'(dc), 64'(78));
    check("b_done_count", 64'(nd), 64'(1));
    check("b_en_edges",   64'(ne), 64'(58));
    check("b_image",      64'(chain), 64'(EXP_IMAGE));
    check("b_parity",     64'(tail_parity), 64'(1));

    // start poked during SHIFT and DONE, chain all ones.
    preload('1);
    run_load(1'b0, 1'b1, 1'b0, dc, nd, ne);
    check("c_done_cycle", 64'(dc), 64'(68));
    check("c_done_count", 64'(nd), 64'(1));
    check("c_en_edges",   64'(ne), 64'(58));
    check("c_image",      64'(chain), 64'(EXP_IMAGE));
    check("c_parity",     64'(tail_parity), 64'(0));

    // Reset after 20 shifts, then a fresh complete load.
    run_load(1'b0, 1'b0, 1'b1, dc, nd, ne);
    repeat (2) begin
      @(posedge prog_clk); #1;
      start = 1'b1;
      check("busy_in_reset2", 64'(busy), 64'(0));
    end
    @(posedge prog_clk); #1;
    start = 1'b0;
    #2 pReset = 1'b0;
    @(posedge prog_clk); #1;
    run_load(1'b0, 1'b0, 1'b0, dc, nd, ne);
    check("d_done_cycle", 64'(dc), 64'(68));
    check("d_done_count", 64'(nd), 64'(1));
    check("d_en_edges",   64'(ne), 64'(58));
    check("d_image",      64'(chain), 64'(EXP_IMAGE));
    check("d_bit_count",  64'(bit_count), 64'(58));

    repeat (2) @(posedge prog_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
# ccff_chain_loader

Configuration-chain loader that sits directly upstream of a connection/switch block's configuration flip-flop chain and drives its `ccff_head`. It accepts configuration words over a valid/ready stream, serialises them MSB-first, and shifts exactly CHAIN_LEN bits into the chain. It drives a shift enable that gates `prog_clk` to the chain, so the chain moves only when a valid bit is presented. While loading, it returns a running parity of the old chain contents observed on `ccff_tail`.

## Interface
- CHAIN_LEN, 58, number of configuration bits in the downstream chain (9×6 + 2×2 for a cby tile)
- DATA_WIDTH, 8, bits per input word
- CNT_W, clog2(CHAIN_LEN+1), width of bit counter (derived, not overridden)

Ports:
- Clock and reset: one clock, `prog_clk`; reset `pReset` is asynchronous and active-high.
- prog_clk  in  1  configuration clock; all state on rising edge
- pReset  in  1  asynchronous active-high reset
- start  in  1  single-cycle request to begin a load; honoured only in IDLE
- s_valid  in  1  input word valid
- s_data  in  DATA_WIDTH  input word; bit DATA_WIDTH-1 shifted first
- s_ready  out  1  loader accepts s_data this cycle
- ccff_head  out  1  serial data to chain head (registered)
- chain_clk_en  out  1  registered; chain flops capture on the prog_clk edge ending a cycle where this is 1
- ccff_tail  in  1  serial data from chain tail
- busy  out  1  high from start acceptance until DONE
- done  out  1  one-cycle pulse after the last bit is shifted
- bit_count  out  CNT_W  bits shifted so far in current load
- tail_parity  out  1  XOR of ccff_tail sampled at every enabled edge of current load

## Operation
- FSM states: IDLE, FETCH, SHIFT, DONE.
- IDLE: busy=0, s_ready=0, chain_clk_en=0.
  - start=1 → FETCH.
  - On that edge, bit_count and tail_parity clear to 0.
- FETCH: s_ready=1, chain_clk_en=0.
  - On s_valid&&s_ready: s_data loads into a shift register and a word bit counter is set to DATA_WIDTH.
  - Next state is SHIFT.
  - Without s_valid, remain in FETCH indefinitely; the chain holds.
- SHIFT: chain_clk_en=1, ccff_head = shreg MSB. On each edge:
  - tail_parity ^= ccff_tail;
  - shreg shifts left by 1;
  - bit_count += 1;
  - word bit counter -= 1.
- SHIFT exit conditions:
  - If bit_count reaches CHAIN_LEN on this edge → DONE; any remaining bits of the current word are discarded.
  - Else, if the word is exhausted → FETCH.
- DONE: done=1 for exactly one cycle, chain_clk_en=0, busy=0 → IDLE.
- Words consumed per load = ceil(CHAIN_LEN/DATA_WIDTH). For the defaults, 8 words; only the top 2 bits of word 7 are used.
- The first bit shifted ends at the tail-most chain position after CHAIN_LEN shifts.
- start outside IDLE is ignored, including in the DONE cycle. s_valid outside FETCH is ignored, and that word is not consumed.
- bit_count and tail_parity hold their final values in IDLE until the next accepted start.

## Timing
- Reset values: s_ready=0, ccff_head=0, chain_clk_en=0, busy=0, done=0, bit_count=0, tail_parity=0; state=IDLE.
- The start edge is followed by 1 FETCH cycle minimum.
- Each word costs 1 FETCH cycle plus DATA_WIDTH SHIFT cycles (fewer for the final partial word) when s_valid is held high.
- ccff_head and chain_clk_en change only right after rising edges; both are stable for a whole cycle, with no glitches, as required for clock gating.
- Exactly CHAIN_LEN cycles with chain_clk_en=1 per load.
- done asserts in the cycle after the final enabled edge. Defaults, no stalls: 1 + 8 FETCH + 58 SHIFT cycles, so done is high in cycle 68 after start.
- pReset mid-load: all outputs return to reset values immediately. The chain keeps a partial, undefined image, and software must issue a new start.

## Test plan
- Reset: assert pReset mid-cycle with random inputs → all outputs 0 asynchronously, state IDLE; start ignored while pReset=1.
- Full load (defaults) with a 58-bit shift model clocked on chain_clk_en, words 0xA5,0x3C,0xFF,0x00,0x81,0x7E,0x5A,0xC0 → model equals the first 58 stream bits; exactly 58 enabled edges; done pulses once at cycle 68; bit_count=58.
- Stalls: drop s_valid for 5 cycles before words 2 and 6 → chain_clk_en stays 0 during stalls; final model image identical to the no-stall run; done delayed by exactly 10 cycles.
- Ignored events:
  - start pulsed during SHIFT and during the DONE cycle → no restart; busy falls after DONE.
  - s_valid in IDLE → s_ready=0, word not consumed.
- Tail parity:
  - Model preloaded with a single 1 → tail_parity=1 after the load.
  - Model preloaded with all 58 ones → tail_parity=0.
- Reset mid-load: pReset after 20 shifts, then a fresh start with the full word set → correct 58-bit image, bit_count=58, done pulsed once.
